// File: rtl/tile_mem.sv
// Shared instruction/data tile memory with host loader port and boot sequencing.
// The host fills the array while the core is held in reset. After boot_done the host shares the array with the core.
module tile_mem #(
    parameter int MEM_WORDS = 4096,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic [3:0]  host_wmask,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    input  logic        host_boot_done,
    output logic        core_rst,
    input  logic [31:0] io_imem_addr,
    output logic [31:0] io_imem_rdata,
    input  logic [31:0] io_dmem_addr,
    input  logic [31:0] io_dmem_wdata,
    input  logic [3:0]  io_dmem_wmask,
    output logic [31:0] io_dmem_rdata,
    output logic [7:0]  oor_count,
    output logic [0:0]  dbg_state
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [31:0] mem [MEM_WORDS];

    logic [0:0]    state;
    logic          run;
    logic [AW-1:0] h_idx, i_idx, d_idx;
    logic          h_oor, i_oor, d_oor;
    logic          host_acc, core_st, oor_hit;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_mask;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, host_addr[1:0], io_imem_addr[1:0], io_dmem_addr[1:0]};

    assign h_idx = host_addr[AW+1:2];
    assign i_idx = io_imem_addr[AW+1:2];
    assign d_idx = io_dmem_addr[AW+1:2];
    assign h_oor = |host_addr[31:AW+2];
    assign i_oor = |io_imem_addr[31:AW+2];
    assign d_oor = |io_dmem_addr[31:AW+2];

    assign run       = (state == ST_RUN);
    assign core_rst  = (state == ST_BOOT);
    assign dbg_state = state;

    // Handshake: a host request transfers on any cycle where host_valid && host_ready.
    // In RUN a pending core store stalls the host, so at most one writer exists per cycle.
    assign host_ready = host_valid && (!run || (io_dmem_wmask == 4'h0));
    assign host_acc   = host_valid && host_ready;
    assign core_st    = run && (io_dmem_wmask != 4'h0);

    assign io_imem_rdata = i_oor ? 32'h0 : mem[i_idx];
    assign io_dmem_rdata = d_oor ? 32'h0 : mem[d_idx];

    // Core fetch/load addresses only count once the core is out of reset.
    assign oor_hit = (host_acc && h_oor) || (run && (i_oor || d_oor));

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = h_idx;
        wr_data = host_wdata;
        wr_mask = host_wmask;
        if (core_st) begin
            wr_en   = !d_oor;
            wr_idx  = d_idx;
            wr_data = io_dmem_wdata;
            wr_mask = io_dmem_wmask;
        end else if (host_acc && host_we) begin
            wr_en = !h_oor;
        end
    end

    // Array is deliberately outside the reset domain so a reset keeps loaded code.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BOOT_HOLD ? ST_BOOT : ST_RUN;
            host_rvalid <= 1'b0;
            host_rdata  <= 32'h0;
            oor_count   <= 8'h0;
        end else begin
            if (state == ST_BOOT && host_boot_done) state <= ST_RUN;
            host_rvalid <= host_acc && !host_we;
            if (host_acc && !host_we) host_rdata <= h_oor ? 32'h0 : mem[h_idx];
            if (oor_hit && oor_count != 8'hFF) oor_count <= oor_count + 8'h1;
        end
    end
endmodule
